// File: rtl/wave_capture_buffer_if.sv
// Bus bundle for the waveform capture buffer: sample input, trigger and arm
// controls, the display read port, and capture status.
interface wave_capture_buffer_if #(
  parameter int SAMPLE_W = 12
);
  logic                sample_en;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] trig_level;
  logic                arm;
  logic                force_trig;
  logic [9:0]          rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic [1:0]          state;
  logic                done;
  logic [9:0]          wr_ptr;

  modport master (
    output sample_en, sample, trig_level, arm, force_trig, rd_addr,
    input  rd_data, state, done, wr_ptr
  );

  modport slave (
    input  sample_en, sample, trig_level, arm, force_trig, rd_addr,
    output rd_data, state, done, wr_ptr
  );
endinterface

// File: rtl/wave_capture_buffer.sv
// Single-shot waveform capture buffer. Once armed, waits for a rising-edge
// crossing of trig_level (or a forced trigger), then records DEPTH consecutive
// samples and freezes them for a display sweep on the registered read port.
module wave_capture_buffer #(
  parameter int SAMPLE_W  = 12,
  parameter int DEPTH     = 640,
  parameter int TRIG_HYST = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  wave_capture_buffer_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [9:0]        LAST_ADDR = 10'(DEPTH - 1);
  localparam logic [10:0]       DEPTH_EXT = 11'(DEPTH);
  localparam logic [SAMPLE_W:0] HYST      = (SAMPLE_W + 1)'(TRIG_HYST);

  logic [1:0]          state_q;
  logic [9:0]          wr_ptr_q;
  logic                done_q;
  logic                force_lat;
  logic [SAMPLE_W-1:0] prev_sample;
  logic [SAMPLE_W-1:0] rd_data_p1;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic                trig;
  logic                wr_en;
  logic [9:0]          wr_addr;

  // Rising crossing: previous sample (plus margin) strictly below the level,
  // current sample at or above it. One extra bit keeps prev+margin from wrapping.
  function automatic logic level_cross(input logic [SAMPLE_W-1:0] prev,
                                       input logic [SAMPLE_W-1:0] cur,
                                       input logic [SAMPLE_W-1:0] lvl);
    logic [SAMPLE_W:0] prev_hyst;
    prev_hyst = {1'b0, prev} + HYST;
    return (prev_hyst < {1'b0, lvl}) && (cur >= lvl);
  endfunction

  // Trigger qualification and buffer write port selection.
  always_comb begin
    trig    = bus.sample_en &&
              (bus.force_trig || force_lat ||
               level_cross(prev_sample, bus.sample, bus.trig_level));
    wr_en   = 1'b0;
    wr_addr = wr_ptr_q;
    if (bus.sample_en) begin
      if (state_q == ARMED && trig) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end else if (state_q == CAPTURE) begin
        wr_en   = 1'b1;
      end
    end
  end

  // Previous-sample register for edge detection, updated on every strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sample <= '0;
    end else if (bus.sample_en) begin
      prev_sample <= bus.sample;
    end
  end

  // Capture FSM, write pointer, done pulse and forced-trigger latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      done_q    <= 1'b0;
      force_lat <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            state_q   <= ARMED;
            wr_ptr_q  <= '0;
            force_lat <= 1'b0;
          end
        end
        ARMED: begin
          if (trig) begin
            state_q   <= CAPTURE;
            wr_ptr_q  <= 10'd1;
            force_lat <= 1'b0;
          end else if (bus.force_trig) begin
            force_lat <= 1'b1;
          end
        end
        CAPTURE: begin
          if (bus.sample_en) begin
            if (wr_ptr_q == LAST_ADDR) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 10'd1;
            end
          end
        end
        DONE: begin
          if (bus.arm) begin
            state_q   <= ARMED;
            wr_ptr_q  <= '0;
            force_lat <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sample buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.sample;
    end
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_p1 <= '0;
    end else if ({1'b0, bus.rd_addr} < DEPTH_EXT) begin
      rd_data_p1 <= mem[bus.rd_addr];
    end else begin
      rd_data_p1 <= '0;
    end
  end

  assign bus.rd_data = rd_data_p1;
  assign bus.state   = state_q;
  assign bus.done    = done_q;
  assign bus.wr_ptr  = wr_ptr_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed bench for wave_capture_buffer: a vector table for trigger/arm/reset
// behaviour plus hand sequences for full captures, readback and aborts.
module tb_wave_capture_buffer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_mem [640];

  wave_capture_buffer_if #(.SAMPLE_W(12)) bus ();

  wave_capture_buffer #(.SAMPLE_W(12), .DEPTH(640), .TRIG_HYST(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs; int en; int smp; int arm; int frc; int ra;
    int chk_rd; int exp_rd; int exp_st; int exp_wp; int exp_dn;
  } vec_t;

  vec_t vt [27];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int smp);
    bus.sample_en = 1'b1;
    bus.sample    = 12'(smp);
    tick();
    bus.sample_en = 1'b0;
  endtask

  // Entries 1..639 of a capture already in progress at wr_ptr=1.
  task automatic fill(input int mult, input int offs);
    int smp;
    for (int i = 1; i < 640; i++) begin
      smp = (i * mult + offs) % 4096;
      strobe(smp);
      exp_mem[i] = smp;
      chk("fill_state", int'(bus.state), (i == 639) ? 3 : 2);
      chk("fill_wr_ptr", int'(bus.wr_ptr), (i == 639) ? 639 : i + 1);
      chk("fill_done", int'(bus.done), (i == 639) ? 1 : 0);
    end
    tick();
    chk("done_pulse_end", int'(bus.done), 0);
    chk("done_hold_state", int'(bus.state), 3);
    chk("done_hold_wr_ptr", int'(bus.wr_ptr), 639);
  endtask

  task automatic sweep();
    for (int a = 0; a < 640; a++) begin
      bus.rd_addr = 10'(a);
      tick();
      chk("sweep_rd_data", int'(bus.rd_data), exp_mem[a]);
    end
    bus.rd_addr = 10'd700;
    tick();
    chk("rd_out_of_range", int'(bus.rd_data), 0);
    bus.rd_addr = 10'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_en  = 1'b0;
    bus.sample     = '0;
    bus.trig_level = 12'd2048;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    bus.rd_addr    = '0;

    //          rs en  smp  arm frc  ra chk  erd  st wp dn
    vt[0]  = '{1, 0,    0, 0, 0,   0, 1,    0, 0, 0, 0};
    vt[1]  = '{0, 1, 3000, 0, 0,   0, 0,    0, 0, 0, 0};
    vt[2]  = '{0, 1, 3000, 1, 0,   0, 0,    0, 1, 0, 0};
    vt[3]  = '{0, 1, 3000, 0, 0,   0, 0,    0, 1, 0, 0};
    vt[4]  = '{0, 1, 3000, 0, 0,   0, 0,    0, 1, 0, 0};
    vt[5]  = '{0, 1, 1000, 0, 0,   0, 0,    0, 1, 0, 0};
    vt[6]  = '{0, 1, 2500, 0, 0,   0, 0,    0, 2, 1, 0};
    vt[7]  = '{0, 1,    7, 0, 0,   0, 1, 2500, 2, 2, 0};
    vt[8]  = '{0, 0,    0, 1, 0,   1, 1,    7, 2, 2, 0};
    vt[9]  = '{0, 0,    0, 0, 1,   1, 1,    7, 2, 2, 0};
    vt[10] = '{0, 1,    9, 0, 0,   1, 1,    7, 2, 3, 0};
    vt[11] = '{0, 1,   11, 0, 0,   2, 1,    9, 2, 4, 0};
    vt[12] = '{1, 0,    0, 0, 0,   3, 1,    0, 0, 0, 0};
    vt[13] = '{0, 0,    0, 0, 0,   3, 1,   11, 0, 0, 0};
    vt[14] = '{0, 0,    0, 1, 0,   0, 0,    0, 1, 0, 0};
    vt[15] = '{0, 0,    0, 0, 1,   0, 0,    0, 1, 0, 0};
    vt[16] = '{0, 0,    0, 1, 0,   0, 0,    0, 1, 0, 0};
    vt[17] = '{0, 1,    5, 0, 0,   0, 1, 2500, 2, 1, 0};
    vt[18] = '{0, 1,    6, 0, 0,   0, 1,    5, 2, 2, 0};
    vt[19] = '{1, 0,    0, 0, 0,   0, 1,    0, 0, 0, 0};
    vt[20] = '{0, 0,    0, 0, 0,   1, 1,    6, 0, 0, 0};
    vt[21] = '{0, 0,    0, 0, 0, 700, 1,    0, 0, 0, 0};
    vt[22] = '{0, 0,    0, 0, 1,   0, 0,    0, 0, 0, 0};
    vt[23] = '{0, 0,    0, 1, 0,   0, 0,    0, 1, 0, 0};
    vt[24] = '{0, 1,  100, 0, 0,   0, 0,    0, 1, 0, 0};
    vt[25] = '{0, 0, 3000, 0, 0,   0, 0,    0, 1, 0, 0};
    vt[26] = '{0, 1, 3000, 0, 0,   0, 0,    0, 2, 1, 0};

    #3;
    chk("async_reset_state", int'(bus.state), 0);
    chk("async_reset_wr_ptr", int'(bus.wr_ptr), 0);
    chk("async_reset_done", int'(bus.done), 0);
    chk("async_reset_rd_data", int'(bus.rd_data), 0);

    foreach (vt[k]) begin
      reset          = vt[k].rs[0];
      bus.sample_en  = vt[k].en[0];
      bus.sample     = 12'(vt[k].smp);
      bus.arm        = vt[k].arm[0];
      bus.force_trig = vt[k].frc[0];
      bus.rd_addr    = 10'(vt[k].ra);
      tick();
      chk($sformatf("vec%0d_state", k), int'(bus.state), vt[k].exp_st);
      chk($sformatf("vec%0d_wr_ptr", k), int'(bus.wr_ptr), vt[k].exp_wp);
      chk($sformatf("vec%0d_done", k), int'(bus.done), vt[k].exp_dn);
      if (vt[k].chk_rd != 0)
        chk($sformatf("vec%0d_rd_data", k), int'(bus.rd_data), vt[k].exp_rd);
    end
    reset          = 1'b0;
    bus.sample_en  = 1'b0;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    bus.rd_addr    = '0;

    // Threshold-triggered capture begun by the last vector: entry0=3000.
    exp_mem[0] = 3000;
    fill(53, 17);

    // Strobes while DONE must not disturb the frozen buffer.
    for (int i = 0; i < 3; i++) begin
      strobe(4095);
      chk("done_no_write_state", int'(bus.state), 3);
      chk("done_no_write_wr_ptr", int'(bus.wr_ptr), 639);
    end
    sweep();

    // Re-arm from DONE mid-sweep; old data still readable.
    bus.rd_addr = 10'd10;
    bus.arm     = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("rearm_state", int'(bus.state), 1);
    chk("rearm_wr_ptr", int'(bus.wr_ptr), 0);
    chk("rearm_rd_data", int'(bus.rd_data), exp_mem[10]);
    for (int a = 11; a <= 20; a++) begin
      bus.rd_addr = 10'(a);
      tick();
      chk("armed_old_data", int'(bus.rd_data), exp_mem[a]);
    end

    // Forced capture, read-first on entry0, then latch must not survive.
    bus.force_trig = 1'b1;
    tick();
    bus.force_trig = 1'b0;
    chk("force_latched_state", int'(bus.state), 1);
    bus.rd_addr = 10'd0;
    strobe(5);
    chk("force_trig_state", int'(bus.state), 2);
    chk("force_trig_wr_ptr", int'(bus.wr_ptr), 1);
    chk("read_first_entry0", int'(bus.rd_data), 3000);
    exp_mem[0] = 5;
    fill(29, 400);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("rearm2_state", int'(bus.state), 1);
    strobe(5);
    chk("force_latch_cleared", int'(bus.state), 1);
    chk("entry0_forced", int'(bus.rd_data), 5);

    // Abort a capture with an asynchronous reset at wr_ptr=300.
    strobe(3000);
    chk("abort_trig_state", int'(bus.state), 2);
    exp_mem[0] = 3000;
    for (int i = 1; i < 300; i++) begin
      strobe(i);
      exp_mem[i] = i;
    end
    chk("abort_wr_ptr", int'(bus.wr_ptr), 300);
    reset = 1'b1;
    #2;
    chk("abort_async_state", int'(bus.state), 0);
    chk("abort_async_wr_ptr", int'(bus.wr_ptr), 0);
    chk("abort_async_done", int'(bus.done), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      strobe(3000 - i);
      chk("abort_no_done", int'(bus.done), 0);
      chk("abort_stays_idle", int'(bus.state), 0);
    end

    // A fresh arm gives a normal capture.
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    strobe(100);
    strobe(3000);
    chk("recapture_state", int'(bus.state), 2);
    chk("recapture_wr_ptr", int'(bus.wr_ptr), 1);
    exp_mem[0] = 3000;
    fill(71, 5);
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
